// File: rtl/preg_freelist.sv
// Physical-register free list.
// Circular FIFO of free preg IDs plus a membership bitmap. Rename pops IDs
// from the head and commit pushes released IDs at the tail. The bitmap lets a
// release of an ID that is already free be rejected, so each ID appears at
// most once in the list.
module preg_freelist #(
  parameter int NREGS = 64,
  parameter int ID_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alloc_i,
  output logic            alloc_valid_o,
  output logic [ID_W-1:0] alloc_preg_o,
  input  logic            free_valid_i,
  input  logic [ID_W-1:0] free_preg_i,
  output logic [ID_W:0]   count_o,
  output logic            overflow_err_o,
  output logic            dfree_err_o
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NREGS);

  logic [ID_W-1:0] list_q [NREGS];
  logic [NREGS-1:0] in_list_q;
  logic [ID_W-1:0] head_q;
  logic [ID_W-1:0] tail_q;
  logic [ID_W:0]   count_q;
  logic            overflow_q;
  logic            dfree_q;

  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            dup;
  logic [ID_W-1:0] head_id;

  // Handshake decode; every term uses pre-edge state only, so alloc_i never
  // reaches the offer outputs and a free into an empty list is not bypassed.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    head_id = list_q[head_q];
    dup     = in_list_q[free_preg_i];
    pop     = alloc_i && !empty;
    push    = free_valid_i && !full && !dup;
  end

  // FIFO storage: reset loads the identity order, pushes write at the tail.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) begin
        list_q[i] <= ID_W'(i);
      end
    end else if (push) begin
      list_q[tail_q] <= free_preg_i;
    end
  end

  // Membership bitmap; a popped ID and a pushed ID never coincide because a
  // push requires the ID to be absent, so the clear and set cannot collide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_list_q <= '1;
    end else begin
      if (pop) begin
        in_list_q[head_id] <= 1'b0;
      end
      if (push) begin
        in_list_q[free_preg_i] <= 1'b1;
      end
    end
  end

  // Head/tail pointers wrap naturally at NREGS (power of two).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
    end
  end

  // Occupancy count; push is gated by !full and pop by !empty, so the count
  // stays within 0..NREGS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= FULL_CNT;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; both may set in the same cycle, only reset clears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      dfree_q    <= 1'b0;
    end else begin
      if (free_valid_i && full) begin
        overflow_q <= 1'b1;
      end
      if (free_valid_i && dup) begin
        dfree_q <= 1'b1;
      end
    end
  end

  // Output drive straight from state.
  always_comb begin
    alloc_valid_o  = !empty;
    alloc_preg_o   = head_id;
    count_o        = count_q;
    overflow_err_o = overflow_q;
    dfree_err_o    = dfree_q;
  end

endmodule

// File: doc/preg_freelist.md
Name: preg_freelist

Overview:
- Physical-register free list. It supplies free preg IDs to the rename stage and accepts released preg IDs from the commit side.
- It is a circular FIFO of preg IDs with a membership bitmap.
- It replaces the rename stage's counter allocator, so pregs can be released and reused in any order.
- Sits between the commit stage (free port) and rename (alloc port).

Parameters:
- NREGS, 64, number of physical registers; must be a power of two, at least 4.
- ID_W, $clog2(NREGS), width of a preg ID.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- alloc_i  input  1  rename consumes the offered ID this cycle.
- alloc_valid_o  output  1  a free ID is offered.
- alloc_preg_o  output  ID_W  offered preg ID (entry at head).
- free_valid_i  input  1  commit releases a preg this cycle.
- free_preg_i  input  ID_W  preg ID being released.
- count_o  output  ID_W+1  number of IDs currently in the list.
- overflow_err_o  output  1  sticky: a free was attempted while the list was full.
- dfree_err_o  output  1  sticky: a free was attempted for an ID already in the list.

Behaviour:
- State:
  - list[NREGS] of ID_W bits.
  - head and tail pointers, ID_W bits each, wrapping modulo NREGS.
  - count, ID_W+1 bits.
  - in_list[NREGS] bitmap.
  - two sticky error flags.
- Reset (asynchronous, rstn=0):
  - list[i]=i; in_list all ones.
  - head=0, tail=0, count=NREGS.
  - Both error flags 0.
  - Outputs during and after reset: alloc_valid_o=1, alloc_preg_o=0, count_o=NREGS, both error outputs 0.
  - Reset asserted mid-operation discards all state immediately; no pending handshake survives.
- Alloc side (combinational offer, valid/ready style):
  - alloc_valid_o = (count != 0).
  - alloc_preg_o = list[head]. The value is don't-care when alloc_valid_o=0, but it must be stable, with no X.
  - A pop occurs iff alloc_i && alloc_valid_o. On a pop: head <= head+1 and in_list[list[head]] <= 0.
  - alloc_i while alloc_valid_o=0 is ignored, with no state change.
  - alloc_i has no combinational path to alloc_valid_o or alloc_preg_o.
- Free side:
  - A push is accepted iff free_valid_i && count != NREGS && !in_list[free_preg_i]. The in_list check uses the pre-edge bitmap.
  - On a push: list[tail] <= free_preg_i, tail <= tail+1, in_list[free_preg_i] <= 1.
  - free_valid_i && count == NREGS: the free is dropped and overflow_err_o is set.
  - free_valid_i && in_list[free_preg_i]: the free is dropped and dfree_err_o is set. This includes the ID being popped in the same cycle.
  - When both error conditions hold in one cycle, both flags set.
  - Error flags clear only on reset.
- Count update:
  - count <= count + push - pop.
  - Simultaneous accepted push and pop leaves count unchanged.
  - count never exceeds NREGS and never underflows.
- Empty boundary:
  - No same-cycle bypass: a free accepted when count=0 makes alloc_valid_o=1 only on the next cycle, with alloc_preg_o equal to the freed ID.
  - alloc_i in the empty cycle is ignored.
- Ordering: strict FIFO. IDs are offered in the order they were freed, after the reset-order IDs ahead of them.
- Latency:
  - Free to reallocatable: 1 cycle when the list was empty.
  - Otherwise the freed ID becomes reallocatable after all IDs ahead of it are consumed.
- Invariant for verification: popcount(in_list) == count at every cycle.

Test Plan:
- Reset then alloc_i=1 for 64 cycles -> alloc_preg_o = 0,1,...,63 in order; count_o 64 down to 0; alloc_valid_o=0 in the cycle after the 64th pop.
- From empty, free 17, 5, 42 on consecutive cycles -> alloc_valid_o=1 the cycle after free 17; subsequent allocs return 17, 5, 42; count_o peaks at 3.
- Empty list, same cycle free_valid_i=1 (ID 9) and alloc_i=1 -> no pop that cycle; next cycle alloc_valid_o=1 with alloc_preg_o=9, count_o=1.
- Count=10, same cycle pop and free of an absent ID 3 -> count_o stays 10; ID 3 is offered after the 9 remaining older IDs.
- After reset, free ID 7 (already present) -> dfree_err_o=1 next cycle and stays 1; count_o stays 64; list unchanged. Same for freeing the ID being popped.
- Assert rstn=0 mid-stream at count 20 -> outputs return immediately to count_o=64, alloc_preg_o=0, error flags 0, without waiting for a clock edge.
